// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store bus sequencer with lane formatting and ack watchdog; define LSU_MISALIGN_TRAP_EN to trap misaligned half/word accesses
module lsu_mem_stage #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] alu_c,
  input  logic [31:0] rD2,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic [3:0]  dm_wstrb,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata
);
  typedef enum logic [1:0] {IDLE, BUS, ERR, DONE} state_t;
  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [1:0]  off_q, off_d, size_q, size_d;
  logic        uns_q, uns_d;
  logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [3:0]  dm_wstrb_q, dm_wstrb_d;
  logic        lsu_done_q, lsu_done_d, lsu_err_q, lsu_err_d;
  logic [31:0] lsu_rdata_q, lsu_rdata_d;
  logic        misal;
  logic [31:0] st_data, ld_fmt;
  logic [3:0]  st_strb;
  logic [7:0]  ld_b;
  logic [15:0] ld_h;
`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = (lsu_size == 2'b01 && alu_c[0]) || (lsu_size[1] && alu_c[1:0] != 2'b00);
`else
  assign misal = 1'b0;
`endif
  assign st_data = lsu_size == 2'b00 ? {4{rD2[7:0]}} : lsu_size == 2'b01 ? {2{rD2[15:0]}} : rD2;
  assign st_strb = !lsu_we ? 4'b0000 : lsu_size == 2'b00 ? 4'b0001 << alu_c[1:0] :
                   lsu_size == 2'b01 ? (alu_c[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  // load lane comes from the address bits latched at accept, not the live ALU value
  assign ld_b   = dm_rdata[{off_q, 3'b000} +: 8];
  assign ld_h   = off_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
  assign ld_fmt = size_q == 2'b00 ? {{24{~uns_q & ld_b[7]}}, ld_b} :
                  size_q == 2'b01 ? {{16{~uns_q & ld_h[15]}}, ld_h} : dm_rdata;
  assign lsu_busy  = (state_q == IDLE && lsu_req) || state_q == BUS || state_q == ERR;
  assign lsu_done  = lsu_done_q;
  assign lsu_err   = lsu_err_q;
  assign lsu_rdata = lsu_rdata_q;
  assign dm_req    = dm_req_q;
  assign dm_we     = dm_we_q;
  assign dm_addr   = dm_addr_q;
  assign dm_wdata  = dm_wdata_q;
  assign dm_wstrb  = dm_wstrb_q;
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    off_d       = off_q;
    size_d      = size_q;
    uns_d       = uns_q;
    dm_req_d    = 1'b0;
    dm_we_d     = 1'b0;
    dm_addr_d   = 32'd0;
    dm_wdata_d  = 32'd0;
    dm_wstrb_d  = 4'd0;
    lsu_done_d  = 1'b0;
    lsu_err_d   = 1'b0;
    lsu_rdata_d = 32'd0;
    case (state_q)
      IDLE: if (lsu_req) begin
        off_d  = alu_c[1:0];
        size_d = lsu_size;
        uns_d  = lsu_unsigned;
        if (misal) state_d = ERR;
        else begin
          state_d    = BUS;
          dm_req_d   = 1'b1;
          dm_we_d    = lsu_we;
          dm_addr_d  = {alu_c[31:2], 2'b00};
          dm_wdata_d = st_data;
          dm_wstrb_d = st_strb;
        end
      end
      BUS: if (dm_ack) begin
        state_d     = DONE;
        lsu_done_d  = 1'b1;
        lsu_rdata_d = dm_we_q ? 32'd0 : ld_fmt;
      end else if (cnt_q == 8'(TIMEOUT - 1)) begin
        state_d    = DONE;
        cnt_d      = cnt_q + 8'd1;
        lsu_done_d = 1'b1;
        lsu_err_d  = 1'b1;
      end else begin
        cnt_d      = cnt_q + 8'd1;
        dm_req_d   = 1'b1;
        dm_we_d    = dm_we_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        dm_wstrb_d = dm_wstrb_q;
      end
      ERR: begin
        state_d    = DONE;
        lsu_done_d = 1'b1;
        lsu_err_d  = 1'b1;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = 8'd0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 8'd0;
      off_q       <= 2'd0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      dm_req_q    <= 1'b0;
      dm_we_q     <= 1'b0;
      dm_addr_q   <= 32'd0;
      dm_wdata_q  <= 32'd0;
      dm_wstrb_q  <= 4'd0;
      lsu_done_q  <= 1'b0;
      lsu_err_q   <= 1'b0;
      lsu_rdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      dm_req_q    <= dm_req_d;
      dm_we_q     <= dm_we_d;
      dm_addr_q   <= dm_addr_d;
      dm_wdata_q  <= dm_wdata_d;
      dm_wstrb_q  <= dm_wstrb_d;
      lsu_done_q  <= lsu_done_d;
      lsu_err_q   <= lsu_err_d;
      lsu_rdata_q <= lsu_rdata_d;
    end
  end
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: randomized scoreboard bench for lsu_mem_stage against a byte-lane reference model
module tb_lsu_mem_stage;
  localparam int TO = 16;
  logic        clk = 0, rst = 1, lsu_req = 0, lsu_we = 0, lsu_unsigned = 0, dm_ack = 0;
  logic [1:0]  lsu_size = 0;
  logic [31:0] alu_c = 0, rD2 = 0, dm_rdata = 0;
  logic        lsu_busy, lsu_done, lsu_err, dm_req, dm_we;
  logic [31:0] lsu_rdata, dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  typedef struct {
    bit          trap, err, chk_rd, we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    int          start, done;
  } exp_t;
  exp_t sb[$];
  int cyc_g = 0, n_cmp = 0, n_err = 0;
  bit flush = 0, prev_rst = 0;
  lsu_mem_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_unsigned(lsu_unsigned), .alu_c(alu_c), .rD2(rD2), .lsu_busy(lsu_busy),
    .lsu_done(lsu_done), .lsu_err(lsu_err), .lsu_rdata(lsu_rdata), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc_g <= cyc_g + 1;
  // reference: an access covers n bytes starting at lane base; store lanes repeat the low n data bytes
  function automatic exp_t model(bit we, bit [1:0] size, bit uns, bit [31:0] addr, bit [31:0] wd,
                                 bit [31:0] mem, int ack_k);
    exp_t   e;
    int     n, base;
    longint v;
    e = '{default: 0};
    n = size == 0 ? 1 : size == 1 ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    e.trap = (addr % n) != 0;
`else
    e.trap = 1'b0;
`endif
    base = int'(addr % 4) - int'(addr % n);
    e.addr = addr & 32'hFFFF_FFFC;
    e.we = we;
    for (int i = 0; i < 4; i++) begin
      e.wstrb[i] = we && i >= base && i < base + n;
      e.wdata[8*i +: 8] = wd[8*(i % n) +: 8];
    end
    v = 0;
    for (int j = 0; j < n; j++) v += longint'(mem[8*(base+j) +: 8]) << (8*j);
    if (!uns && n < 4 && v >= (longint'(1) << (8*n-1))) v -= longint'(1) << (8*n);
    e.err = e.trap || ack_k < 1 || ack_k > TO;
    e.done = e.trap ? 2 : e.err ? TO + 1 : ack_k + 1;
    e.rdata = e.err ? 32'd0 : 32'(v);
    e.chk_rd = !we || e.err;
    return e;
  endfunction
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h expected %h", nm, cyc_g, act, exp);
    end
  endtask
  task automatic do_txn(bit we, bit [1:0] size, bit uns, bit [31:0] addr, bit [31:0] wd,
                        bit [31:0] mem, int ack_k, int gap);
    exp_t e;
    e = model(we, size, uns, addr, wd, mem, ack_k);
    @(posedge clk); #2;
    lsu_req = 1; lsu_we = we; lsu_size = size; lsu_unsigned = uns; alu_c = addr; rD2 = wd;
    dm_ack = $urandom_range(0, 3) == 0;
    dm_rdata = $urandom;
    e.start = cyc_g;
    sb.push_back(e);
    for (int rel = 1; rel <= e.done; rel++) begin
      @(posedge clk); #2;
      alu_c = $urandom; rD2 = $urandom;
      dm_ack = rel == e.done ? $urandom_range(0, 1) == 1 : rel == ack_k;
      dm_rdata = (dm_ack && rel == ack_k) ? mem : $urandom;
    end
    repeat (gap) begin
      @(posedge clk); #2;
      lsu_req = 0;
      dm_ack = $urandom_range(0, 3) == 0;
    end
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    bit   have, in_bus;
    int   rel;
    if (flush) begin
      sb.delete();
      flush = 0;
    end
    if (prev_rst) begin
      chk("rst_dm_req", dm_req, 0);
      chk("rst_dm_we", dm_we, 0);
      chk("rst_dm_addr", dm_addr, 0);
      chk("rst_dm_wdata", dm_wdata, 0);
      chk("rst_dm_wstrb", dm_wstrb, 0);
      chk("rst_done", lsu_done, 0);
      chk("rst_err", lsu_err, 0);
      chk("rst_rdata", lsu_rdata, 0);
    end
    have = sb.size() > 0;
    e = '{default: 0};
    if (have) e = sb[0];
    rel = cyc_g - e.start;
    in_bus = have && !e.trap && rel >= 1 && rel < e.done;
    chk("busy", lsu_busy, have ? rel < e.done : lsu_req);
    chk("dm_req", dm_req, in_bus);
    chk("done", lsu_done, have && rel == e.done);
    if (in_bus && dm_req) begin
      chk("dm_addr", dm_addr, e.addr);
      chk("dm_we", dm_we, e.we);
      chk("dm_wstrb", dm_wstrb, e.wstrb);
      if (e.we) chk("dm_wdata", dm_wdata, e.wdata);
    end
    if (have && rel == e.done && lsu_done) begin
      chk("err", lsu_err, e.err);
      if (e.chk_rd) chk("rdata", lsu_rdata, e.rdata);
    end
    if (have && rel >= e.done) void'(sb.pop_front());
    prev_rst = rst;
    if (rst) flush = 1;
  end
  initial begin
    exp_t e;
    repeat (3) @(posedge clk);
    #2 rst = 0;
    do_txn(1, 2, 0, 32'h100, 32'hDEADBEEF, 0, 1, 1);
    do_txn(1, 0, 0, 32'h103, 32'h123456A5, 0, 1, 0);
    do_txn(0, 0, 0, 32'h102, 0, 32'h12803456, 1, 0);
    do_txn(0, 0, 1, 32'h102, 0, 32'h12803456, 2, 1);
    do_txn(0, 1, 1, 32'h102, 0, 32'h12803456, 3, 0);
    do_txn(0, 1, 0, 32'h101, 0, 32'h12348765, 1, 1);
    do_txn(1, 2, 0, 32'h10A, 32'h0BADF00D, 0, 2, 0);
    do_txn(0, 2, 0, 32'h104, 0, 32'h55AA55AA, 0, 1);
    do_txn(0, 2, 0, 32'h108, 0, 32'hCAFEF00D, TO, 0);
    // reset in the 4th BUS cycle after three unacknowledged waits, then a stray ack
    e = model(0, 2, 0, 32'h200, 0, 0, 0);
    @(posedge clk); #2;
    lsu_req = 1; lsu_we = 0; lsu_size = 2; lsu_unsigned = 0; alu_c = 32'h200; dm_ack = 0;
    e.start = cyc_g;
    sb.push_back(e);
    repeat (4) begin @(posedge clk); #2; end
    rst = 1;
    @(posedge clk); #2;
    dm_ack = 1;
    @(posedge clk); #2;
    rst = 0; lsu_req = 0;
    @(posedge clk); #2;
    dm_ack = 0;
    for (int i = 0; i < 300; i++) begin
      int r, k;
      r = $urandom_range(0, 9);
      k = r < 5 ? 1 : r < 8 ? int'($urandom_range(2, TO)) : r == 8 ? TO : 0;
      do_txn(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             $urandom, $urandom, $urandom, k, $urandom_range(0, 2));
    end
    @(posedge clk); #2;
    lsu_req = 0; dm_ack = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
